// File: rtl/sobel_frame_scheduler.sv
// Frame-granular round-robin arbiter and sequencer in front of sobel_stage.
// Optional drain watchdog is built only when SOBEL_SCHED_TIMEOUT_EN is defined.
module sobel_frame_scheduler #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned IMG_WIDTH      = 128,
  parameter int unsigned IMG_HEIGHT     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       sched_en,
  input  logic [8*NUM_SRC-1:0]       s_axis_tdata,
  input  logic [NUM_SRC-1:0]         s_axis_tvalid,
  input  logic [NUM_SRC-1:0]         s_axis_tlast,
  output logic [NUM_SRC-1:0]         s_axis_tready,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  input  logic                       sob_tvalid,
  input  logic                       sob_tready,
  input  logic                       sob_tlast,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic                       timeout,
  output logic [15:0]                frame_cnt
);

  localparam int unsigned GW   = $clog2(NUM_SRC);
  localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned PW   = $clog2(NPIX);
  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [GW-1:0]   grant_next;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   cand;
  logic            pick_vld;
  logic [PW-1:0]   pix_cnt;
  logic [7:0]      sel_data;
  logic            sel_valid;
  logic            sel_last;
  logic            stream_hs;
  logic            is_last;
  logic            sob_end;
  logic            wd_expire;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick     = grant_id;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand = GW'((32'(grant_id) + i) % NUM_SRC);
      if (!pick_vld && s_axis_tvalid[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // Select the granted source's stream.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (GW'(i) == grant_id) begin
        sel_data  = s_axis_tdata[8*i +: 8];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  assign is_last   = (pix_cnt == LAST_PIX);
  assign stream_hs = (state == S_STREAM) && sel_valid && m_axis_tready;
  assign sob_end   = sob_tvalid && sob_tready && sob_tlast;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      grant_id <= GW'(NUM_SRC - 1);
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      grant_id <= grant_next;
      busy     <= (state_next != S_IDLE);
    end
  end

  // Next-state and grant selection.
  always_comb begin
    state_next = state;
    grant_next = grant_id;
    case (state)
      S_IDLE: begin
        if (sched_en && pick_vld) begin
          state_next = S_STREAM;
          grant_next = pick;
        end
      end
      S_STREAM: begin
        if (stream_hs && is_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (sob_end || wd_expire) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Zero-latency forwarding; only the owner sees ready, and only while streaming.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == S_STREAM) begin
      m_axis_tdata  = sel_data;
      m_axis_tvalid = sel_valid;
      m_axis_tlast  = is_last;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (GW'(i) == grant_id) s_axis_tready[i] = m_axis_tready;
      end
    end
  end

  // Pixel counter, frame counter and status pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_cnt    <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= (state == S_DRAIN) && sob_end;
      frame_err  <= stream_hs && (sel_last != is_last);
      if (stream_hs) pix_cnt <= is_last ? '0 : pix_cnt + PW'(1);
      if ((state == S_DRAIN) && sob_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef SOBEL_SCHED_TIMEOUT_EN
  logic [31:0] wd_cnt;

  // Watchdog runs only in DRAIN and is held at zero elsewhere, so it restarts on entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= '0;
    end else if (state != S_DRAIN) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

  assign wd_expire = (state == S_DRAIN) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) && !sob_end;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) timeout <= 1'b0;
    else         timeout <= wd_expire;
  end
`else
  logic unused_timeout_cfg;

  assign wd_expire          = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Directed scoreboard bench for sobel_frame_scheduler (NUM_SRC=4, 4x4 frames).
// Timeout scenario is exercised when SOBEL_SCHED_TIMEOUT_EN is defined.
module tb_sobel_frame_scheduler;

  localparam int NS   = 4;
  localparam int NPIX = 16;
`ifdef SOBEL_SCHED_TIMEOUT_EN
  localparam int SOB_DLY = 4;
`else
  localparam int SOB_DLY = 20;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        sched_en;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tvalid;
  logic [3:0]  s_axis_tlast;
  logic [3:0]  s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        sob_tvalid;
  logic        sob_tready;
  logic        sob_tlast;
  logic [1:0]  grant_id;
  logic        busy;
  logic        frame_done;
  logic        frame_err;
  logic        timeout;
  logic [15:0] frame_cnt;

  sobel_frame_scheduler #(
    .NUM_SRC       (4),
    .IMG_WIDTH     (4),
    .IMG_HEIGHT    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sched_en     (sched_en),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .sob_tvalid   (sob_tvalid),
    .sob_tready   (sob_tready),
    .sob_tlast    (sob_tlast),
    .grant_id     (grant_id),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .timeout      (timeout),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } pix_t;

  pix_t       src_q [NS][$];
  pix_t       sb_q [$];
  logic [1:0] grant_log [$];
  logic [1:0] cur_grant;
  logic [3:0] rdy_seen;
  int         checks, passed, failed;
  int         src_pix, tot_hs, done_cnt, err_cnt, to_cnt, exp_done, cyc;
  bit         gap_en, tog_en, frame_end_seen, prev_busy;
  int         exp_g2 [4] = '{2, 0, 2, 0};
  int         exp_g5 [4] = '{0, 1, 2, 3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input int src, input logic [7:0] base, input int extra_last);
    pix_t p;
    for (int k = 0; k < NPIX; k++) begin
      p.d = base + 8'(k);
      p.l = (k == NPIX - 1) || (k == extra_last);
      src_q[src].push_back(p);
    end
  endtask

  // One clock: drive sources at negedge, sample/score at +2, then advance to next negedge.
  task automatic tick();
    pix_t p;
    logic m_hs;
    int   n_src_hs;
    bit   v;
    for (int i = 0; i < NS; i++) begin
      v = (src_q[i].size() != 0) && !(gap_en && ($urandom_range(0, 3) == 0));
      s_axis_tvalid[i] = v;
      if (src_q[i].size() != 0) begin
        s_axis_tdata[8*i +: 8] = src_q[i][0].d;
        s_axis_tlast[i]        = src_q[i][0].l;
      end else begin
        s_axis_tdata[8*i +: 8] = 8'h00;
        s_axis_tlast[i]        = 1'b0;
      end
    end
    m_axis_tready = tog_en ? cyc[0] : 1'b1;
    #2;
    rdy_seen |= s_axis_tready;
    m_hs     = m_axis_tvalid && m_axis_tready;
    n_src_hs = 0;
    for (int i = 0; i < NS; i++) begin
      if (s_axis_tvalid[i] && s_axis_tready[i]) begin
        p   = src_q[i].pop_front();
        p.l = (src_pix == NPIX - 1);
        src_pix = (src_pix == NPIX - 1) ? 0 : src_pix + 1;
        sb_q.push_back(p);
        n_src_hs++;
      end
    end
    if (m_hs || n_src_hs != 0) check("hs_pair", 32'(n_src_hs), {31'd0, m_hs});
    if (m_hs) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        p = sb_q.pop_front();
        check("tdata", m_axis_tdata, p.d);
        check("tlast", m_axis_tlast, p.l);
        tot_hs++;
        if (p.l) frame_end_seen = 1'b1;
      end
    end
    if (!busy) check("idle_quiet", {s_axis_tready, m_axis_tvalid, m_axis_tlast}, 0);
    if (busy && !prev_busy) begin
      grant_log.push_back(grant_id);
      cur_grant = grant_id;
    end else if (busy) begin
      check("grant_hold", grant_id, cur_grant);
    end
    prev_busy = busy;
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
    if (timeout)    to_cnt++;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_frame_end();
    int b;
    b = 0;
    while (!frame_end_seen && b < 400) begin
      tick();
      b++;
    end
    check("frame_end_reached", {31'd0, frame_end_seen}, 1);
    frame_end_seen = 1'b0;
  endtask

  // Stream one frame, then emit sobel output beats and its tlast.
  task automatic run_frame(input int sob_delay);
    wait_frame_end();
    sob_tvalid = 1'b1;
    sob_tready = 1'b1;
    sob_tlast  = 1'b0;
    repeat (sob_delay) tick();
    sob_tlast  = 1'b1;
    sob_tready = 1'b0;
    tick();
    check("no_done_wo_ready", done_cnt, exp_done);
    sob_tready = 1'b1;
    tick();
    sob_tvalid = 1'b0;
    sob_tready = 1'b0;
    sob_tlast  = 1'b0;
    exp_done++;
    tick();
    check("frame_done_cnt", done_cnt, exp_done);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bcnt, k, to0;
    checks = 0; passed = 0; failed = 0;
    src_pix = 0; tot_hs = 0; done_cnt = 0; err_cnt = 0; to_cnt = 0; exp_done = 0; cyc = 0;
    gap_en = 1'b0; tog_en = 1'b0; frame_end_seen = 1'b0; prev_busy = 1'b0;
    cur_grant = 2'd0; rdy_seen = '0;
    resetn = 1'b0; sched_en = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0; m_axis_tready = 1'b0;
    sob_tvalid = 1'b0; sob_tready = 1'b0; sob_tlast = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 3);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_ready", s_axis_tready, 0);
    check("rst_mvalid_mlast", {m_axis_tvalid, m_axis_tlast}, 0);
    check("rst_pulses", {frame_done, frame_err, timeout}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // 1: single frame from source 0
    load_frame(0, 8'h10, -1);
    sched_en = 1'b1;
    run_frame(SOB_DLY);
    check("t1_hs", tot_hs, 16);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_grant", grant_id, 0);
    check("t1_ngrants", 32'(grant_log.size()), 1);
    check("t1_err", err_cnt, 0);

    // 2: sources 0 and 2 contend continuously
    load_frame(0, 8'h20, -1);
    load_frame(2, 8'h40, -1);
    load_frame(0, 8'h30, -1);
    load_frame(2, 8'h50, -1);
    grant_log.delete();
    rdy_seen = '0;
    repeat (4) run_frame(2);
    check("t2_ngrants", 32'(grant_log.size()), 4);
    for (int i = 0; i < 4; i++) check("t2_grant_seq", grant_log[i], exp_g2[i]);
    check("t2_rdy_1_3", rdy_seen & 4'b1010, 0);
    check("t2_frame_cnt", frame_cnt, 5);
    check("t2_hs", tot_hs, 80);

    // 3: source 1 raises tlast early on pixel 9
    load_frame(1, 8'h60, 9);
    grant_log.delete();
    run_frame(3);
    check("t3_err", err_cnt, 1);
    check("t3_hs", tot_hs, 96);
    check("t3_grant", grant_id, 1);
    check("t3_frame_cnt", frame_cnt, 6);

    // 4: sink back-pressure and source gaps
    load_frame(3, 8'h80, -1);
    gap_en = 1'b1;
    tog_en = 1'b1;
    run_frame(1);
    gap_en = 1'b0;
    tog_en = 1'b0;
    check("t4_hs", tot_hs, 112);
    check("t4_grant", grant_id, 3);
    check("t4_frame_cnt", frame_cnt, 7);
    check("t4_err", err_cnt, 1);

    // 5: sched_en dropped mid-frame; IDLE must hold with every source valid
    load_frame(0, 8'h90, -1);
    load_frame(1, 8'hA0, -1);
    load_frame(2, 8'hB0, -1);
    load_frame(3, 8'hC0, -1);
    grant_log.delete();
    repeat (4) tick();
    sched_en = 1'b0;
    run_frame(2);
    bcnt = 0;
    repeat (10) begin
      tick();
      if (busy) bcnt++;
    end
    check("t5_idle_hold", bcnt, 0);
    check("t5_valid_all", s_axis_tvalid, 4'b1110);
    check("t5_ngrants_off", 32'(grant_log.size()), 1);
    sched_en = 1'b1;
    repeat (3) run_frame(1);
    check("t5_ngrants", 32'(grant_log.size()), 4);
    for (int i = 0; i < 4; i++) check("t5_grant_seq", grant_log[i], exp_g5[i]);
    check("t5_frame_cnt", frame_cnt, 11);
    check("t5_hs", tot_hs, 176);

`ifdef SOBEL_SCHED_TIMEOUT_EN
    // 6a: drain watchdog expires without sobel tlast
    load_frame(0, 8'hD0, -1);
    to0 = to_cnt;
    wait_frame_end();
    k = 0;
    while (to_cnt == to0 && k < 40) begin
      tick();
      k++;
    end
    check("t6_timeout_lat", k, 9);
    check("t6_busy_after_to", busy, 0);
    tick();
    tick();
    check("t6_timeout_pulses", to_cnt, to0 + 1);
    check("t6_frame_cnt", frame_cnt, 11);
    check("t6_done_cnt", done_cnt, exp_done);
`else
    check("t6_no_timeout", to_cnt, 0);
`endif

    // 6b: asynchronous reset in the middle of a frame
    load_frame(1, 8'hE0, -1);
    k = 0;
    while (!busy && k < 20) begin
      tick();
      k++;
    end
    check("t6_pre_busy", busy, 1);
    repeat (3) tick();
    check("t6_pre_grant", grant_id, 1);
    #1 resetn = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_grant", grant_id, 3);
    check("t6_rst_frame_cnt", frame_cnt, 0);
    check("t6_rst_ready", s_axis_tready, 0);
    check("t6_rst_mvalid_mlast", {m_axis_tvalid, m_axis_tlast}, 0);
    check("t6_rst_pulses", {frame_done, frame_err, timeout}, 0);
    for (int i = 0; i < NS; i++) src_q[i].delete();
    sb_q.delete();
    src_pix = 0;
    frame_end_seen = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
